// File: rtl/dragon_pkg.sv
// Shared definitions for the dragon body queue.
//   - len_upd_e : legacy 2-bit length-update code (MOVE/HEAL/HIT/IDLE).
//   - DEF_ORIENT_W / DEF_POS_W : default segment field widths.
//   - seg_w()   : packed segment width {orientation, position}.
//   - ORIENT_*  : orientation encodings carried in the upper segment bits.
package dragon_pkg;

  localparam int DEF_ORIENT_W = 2;
  localparam int DEF_POS_W    = 8;

  typedef enum logic [1:0] {
    LU_MOVE = 2'b00,
    LU_HEAL = 2'b01,
    LU_HIT  = 2'b10,
    LU_IDLE = 2'b11
  } len_upd_e;

  localparam logic [DEF_ORIENT_W-1:0] ORIENT_UP    = 2'd0;
  localparam logic [DEF_ORIENT_W-1:0] ORIENT_RIGHT = 2'd1;
  localparam logic [DEF_ORIENT_W-1:0] ORIENT_DOWN  = 2'd2;
  localparam logic [DEF_ORIENT_W-1:0] ORIENT_LEFT  = 2'd3;

  function automatic int seg_w(input int orient_w, input int pos_w);
    return orient_w + pos_w;
  endfunction

endpackage

// File: rtl/dragon_collide_cmp.sv
// N-way position equality against a masked vector, OR-reduced.
// Ports:
//   key  in  W        position to look for
//   vals in  N x W    candidate positions (lane i at vals[i])
//   mask in  N        lane i participates only when mask[i]=1
//   hit  out 1        any participating lane equals key
module dragon_collide_cmp #(
  parameter int N = 7,
  parameter int W = 8
) (
  input  logic [W-1:0]        key,
  input  logic [N-1:0][W-1:0] vals,
  input  logic [N-1:0]        mask,
  output logic                hit
);

  logic [N-1:0] lane_hit;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign lane_hit[i] = mask[i] && (vals[i] == key);
  end

  assign hit = |lane_hit;

endmodule

// File: rtl/dragon_body_queue.sv
// Dragon body: shift-register queue of MAX_SEGS trailing segments plus a
// saturating length counter that drives per-segment display enables.
// Optional self-collision detection is built when DRAGON_SELF_COLLIDE_EN
// is defined; otherwise collide is tied low.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   move_tick    advance queue one step (head_in -> seg 0)
//   head_in      {orientation, position} of the head
//   grow/shrink  length +1 / -1 pulses (both at once cancel)
//   segments     flat bus, segment i at slice i (0 nearest head)
//   seg_en       thermometer enables, bit i set when i < length
//   length       active segment count 0..MAX_SEGS
//   full/empty   length == MAX_SEGS / length == 0
//   underflow    1-cycle pulse on shrink at length 0
//   collide      1-cycle pulse, head hits its own body on a move
import dragon_pkg::*;

module dragon_body_queue #(
  parameter  int MAX_SEGS = 7,
  parameter  int POS_W    = DEF_POS_W,
  parameter  int ORIENT_W = DEF_ORIENT_W,
  localparam int LEN_W    = $clog2(MAX_SEGS + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   move_tick,
  input  logic [ORIENT_W+POS_W-1:0]              head_in,
  input  logic                                   grow,
  input  logic                                   shrink,
  output logic [MAX_SEGS*(ORIENT_W+POS_W)-1:0]   segments,
  output logic [MAX_SEGS-1:0]                    seg_en,
  output logic [LEN_W-1:0]                       length,
  output logic                                   full,
  output logic                                   empty,
  output logic                                   underflow,
  output logic                                   collide
);

  localparam int              SEG_W   = seg_w(ORIENT_W, POS_W);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_SEGS);

  logic [MAX_SEGS-1:0][SEG_W-1:0] seg_q;
  logic [LEN_W-1:0]               len_q;
  logic                           underflow_q;

  // Every slot shifts regardless of seg_en so a newly enabled tail
  // already holds the real trail position.
  always_ff @(posedge clk) begin
    if (!rst_n)         seg_q <= '0;
    else if (move_tick) seg_q <= {seg_q[MAX_SEGS-2:0], head_in};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= 1'b0;
      case ({grow, shrink})
        2'b10: if (len_q != MAX_LEN) len_q <= len_q + LEN_W'(1);
        2'b01: begin
          if (len_q == '0) underflow_q <= 1'b1;
          else             len_q       <= len_q - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < MAX_SEGS; i++) begin : g_en
    assign seg_en[i] = (int'(len_q) > i);
  end

  assign segments  = seg_q;
  assign length    = len_q;
  assign full      = (len_q == MAX_LEN);
  assign empty     = (len_q == '0);
  assign underflow = underflow_q;

`ifdef DRAGON_SELF_COLLIDE_EN
  logic [MAX_SEGS-1:0][POS_W-1:0] seg_pos;
  logic [MAX_SEGS-1:0]            cmp_mask;
  logic                           hit;
  logic                           collide_q;

  // Tail (i == length-1) is excluded: it vacates on this very move.
  for (genvar i = 0; i < MAX_SEGS; i++) begin : g_cmp
    assign seg_pos[i]  = seg_q[i][POS_W-1:0];
    assign cmp_mask[i] = (int'(len_q) > i + 1);
  end

  dragon_collide_cmp #(.N(MAX_SEGS), .W(POS_W)) u_cmp (
    .key  (head_in[POS_W-1:0]),
    .vals (seg_pos),
    .mask (cmp_mask),
    .hit  (hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) collide_q <= 1'b0;
    else        collide_q <= move_tick && hit;
  end

  assign collide = collide_q;
`else
  assign collide = 1'b0;
`endif

endmodule

// File: doc/dragon_body_queue.md
Name: dragon_body_queue

Overview:
- Parametrised dragon body: a shift-register queue of up to MAX_SEGS trailing segments, each holding {orientation, position}.
- On every movement tick, the head snapshot shifts in and all segments follow. A length counter with grow/shrink pulses drives the per-segment display enables.
- Adds length/full/empty status and a registered self-collision pulse. Sits between the dragon head/movement controller and the sprite renderer.

Parameters:
- MAX_SEGS, 7, number of body segments (≥2).
- POS_W, 8, position field width.
- ORIENT_W, 2, orientation field width.
- LEN_W, $clog2(MAX_SEGS+1), length counter width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- move_tick  in  1  single-cycle pulse; advance the queue one step.
- head_in  in  ORIENT_W+POS_W  current head {orientation[MSBs], position[LSBs]}.
- grow  in  1  single-cycle pulse; length +1 (HEAL).
- shrink  in  1  single-cycle pulse; length −1 (HIT).
- segments  out  MAX_SEGS*(ORIENT_W+POS_W)  flat bus; segment i at slice i (segment 0 nearest head).
- seg_en  out  MAX_SEGS  thermometer display enables; bit i set ⇔ i < length.
- length  out  LEN_W  active segment count, 0..MAX_SEGS.
- full  out  1  length == MAX_SEGS.
- empty  out  1  length == 0.
- underflow  out  1  one-cycle pulse; shrink requested at length 0.
- collide  out  1  one-cycle pulse; self-collision detected on a move (see Optional Feature).

Behaviour:
- Reset: clk rising edge with rst_n=0 clears segments, seg_en, length, underflow and collide to 0. full=0, empty=1. Reset overrides all other inputs in the same cycle.
- Shift: on an edge with move_tick=1, seg[0]←head_in and seg[i]←seg[i−1]. All MAX_SEGS slots shift regardless of seg_en, so a newly enabled tail inherits the true trail position.
- Latency: shifted data is visible on the cycle after the move_tick edge. move_tick=0 holds all segment contents.
- Length update, evaluated every edge:
  - grow=1, shrink=0: length+1, saturating at MAX_SEGS. Grow while full is silently ignored.
  - shrink=1, grow=0: length−1. At length 0, length stays 0 and underflow pulses for 1 cycle.
  - grow=1, shrink=1: no change, no underflow.
  - Neither: hold.
- Length updates are independent of move_tick. Both may occur on the same edge.
- seg_en, full and empty are combinational decodes of the registered length, so they change in the same cycle as length.
- length is the single source of truth. No separate state machine is required; the "states" EMPTY / PARTIAL / FULL are decodes of length.
- Mid-operation reset: any cycle with rst_n=0 discards pending pulses. The first move_tick after release shifts head_in into an all-zero queue.
- Input contract: grow and shrink must be pulses. A level held for N cycles counts as N events; this is not filtered.

Optional Feature:
- Macro: DRAGON_SELF_COLLIDE_EN.
- Defined:
  - On an edge with move_tick=1, compare head_in[POS_W-1:0] against the pre-shift position of each segment i where seg_en[i]=1 and i < length−1. The tail is excluded because it vacates on this move.
  - Any match sets collide=1 for exactly one cycle, aligned with the shifted data.
  - length ≤ 1 never collides. Orientation bits are ignored.
- Undefined: no comparator logic is built and collide is tied to 0.

Decomposition:
- dragon_pkg:
  - lengthUpdate encodings (MOVE=2'b00, HEAL=2'b01, HIT=2'b10, IDLE=2'b11) for adapters that still drive the 2-bit code.
  - Default ORIENT_W/POS_W.
  - Function seg_w() = ORIENT_W+POS_W.
  - Orientation constants.
- One natural sub-module: dragon_collide_cmp.
  - Parametrised MAX_SEGS-way position equality against a masked vector, OR-reduced.
  - Instantiated only under DRAGON_SELF_COLLIDE_EN.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles, then release → segments=0, seg_en=0, length=0, empty=1, full=0. 3 move_ticks with head_in=10'h1_05 → segments 0..2 = 10'h105, seg_en still 0.
- Grow/saturate (MAX_SEGS=7): 9 grow pulses → length steps 1..7 then holds at 7; seg_en=7'h7F; full=1 from the 7th pulse on.
- Trail integrity: length=3; move_tick with head_in positions 0x11, 0x12, 0x13, 0x14 → seg0..3 = 0x14, 0x13, 0x12, 0x11. Then grow → seg_en=4'hF and seg3 shows 0x11 with no new shift.
- Shrink/underflow: from length=1, shrink → length=0, empty=1, no underflow. A second shrink → length stays 0 and underflow=1 for exactly 1 cycle.
- Simultaneous events: length=4; grow+shrink+move_tick on the same edge → length=4 and queue shifted once. Repeat with rst_n=0 on the same edge → all cleared.
- Collision (macro defined): length=4, seg positions 0x20, 0x21, 0x22, 0x23.
  - head_in=0x21 with move_tick → collide=1 for 1 cycle.
  - head_in=0x23 (tail) → collide=0.
  - With macro undefined, collide stays 0.
